// File: rtl/encoder_seq_if.sv
// encoder_seq_if: request lines, ack handshake and grant outputs between a request source and encoder_seq
interface encoder_seq_if;
  logic D3, D2, D1, D0;
  logic ack;
  logic I1, I0;
  logic valid;
  logic overrun;
  modport master(output D3, D2, D1, D0, ack, input I1, I0, valid, overrun);
  modport slave(input D3, D2, D1, D0, ack, output I1, I0, valid, overrun);
endinterface

// File: rtl/encoder_seq.sv
// encoder_seq: rising-edge request capture with a 2-bit registered grant and ack handshake; ENCODER_SEQ_RR_EN selects round-robin
module encoder_seq (
  input logic clk,
  input logic rst_n,
  encoder_seq_if.slave bus
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic [3:0] d, dq_q, dq_d, p_q, p_d, ev, clr;
  logic [1:0] idx_q, idx_d, sel;
  logic valid_q, valid_d, ovr_q, ovr_d, grant;
  assign d = {bus.D3, bus.D2, bus.D1, bus.D0};
  assign ev = d & ~dq_q;
  assign grant = (state_q == IDLE) && (|p_q);
`ifdef ENCODER_SEQ_RR_EN
  logic [1:0] ptr_q, ptr_d, start, off;
  logic [3:0] rot;
  assign start = ptr_q + 2'd1;
  assign rot = 4'({p_q, p_q} >> start);
  assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign sel = start + off;
  // last-granted pointer; reset to 3 so the first search begins at line 0
  always_comb ptr_d = grant ? sel : ptr_q;
  // pointer register
  always_ff @(posedge clk) ptr_q <= !rst_n ? 2'd3 : ptr_d;
`else
  assign sel = p_q[3] ? 2'd3 : p_q[2] ? 2'd2 : p_q[1] ? 2'd1 : 2'd0;
`endif
  // capture events into pending (new event beats grant-clear), detect merges, step the grant FSM
  always_comb begin
    clr = grant ? (4'b0001 << sel) : 4'b0000;
    dq_d = d;
    p_d = (p_q & ~clr) | ev;
    ovr_d = ovr_q | (|(ev & p_q & ~clr));
    state_d = grant ? HOLD : (state_q == HOLD && bus.ack) ? IDLE : state_q;
    valid_d = grant ? 1'b1 : (state_q == HOLD && bus.ack) ? 1'b0 : valid_q;
    idx_d = grant ? sel : idx_q;
  end
  // state registers; Dq resets high so lines held through reset raise no event
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dq_q <= 4'b1111;
      p_q <= 4'b0000;
      idx_q <= 2'd0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dq_q <= dq_d;
      p_q <= p_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
      ovr_q <= ovr_d;
    end
  end
  assign bus.I1 = idx_q[1];
  assign bus.I0 = idx_q[0];
  assign bus.valid = valid_q;
  assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_encoder_seq.sv
// tb_encoder_seq: vector table, directed corner sequences and a randomized run against a reference model
module tb_encoder_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  encoder_seq_if bus();
  encoder_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    bit rst_n;
    bit [3:0] d;
    bit ack;
    bit vld;
    int code;
    bit ovr;
  } vec_t;

`ifdef ENCODER_SEQ_RR_EN
  localparam int FIRST = 0;
  localparam int SECOND = 3;
`else
  localparam int FIRST = 3;
  localparam int SECOND = 0;
`endif

  bit [3:0] m_prev, m_pend;
  bit m_hold, m_vld, m_ovr;
  int m_code, m_last;

  task automatic model_edge(input bit r, input bit [3:0] dv, input bit a);
    int g;
    bit [3:0] np;
    if (!r) begin
      m_prev = 4'hf; m_pend = 0; m_hold = 0; m_vld = 0; m_code = 0; m_ovr = 0; m_last = 3;
    end else begin
      g = -1;
      if (!m_hold && m_pend != 0) begin
`ifdef ENCODER_SEQ_RR_EN
        for (int k = 1; k <= 4; k++) if (g < 0 && m_pend[(m_last + k) % 4]) g = (m_last + k) % 4;
`else
        for (int i = 0; i < 4; i++) if (m_pend[i]) g = i;
`endif
      end
      np = m_pend;
      for (int i = 0; i < 4; i++) begin
        if (dv[i] && !m_prev[i]) begin
          if (m_pend[i] && i != g) m_ovr = 1;
          np[i] = 1;
        end else if (i == g) np[i] = 0;
      end
      m_pend = np;
      if (m_hold && a) begin m_hold = 0; m_vld = 0; end
      else if (g >= 0) begin m_hold = 1; m_vld = 1; m_code = g; m_last = g; end
      m_prev = dv;
    end
  endtask

  task automatic step(input bit r, input bit [3:0] dv, input bit a);
    rst_n = r;
    {bus.D3, bus.D2, bus.D1, bus.D0} = dv;
    bus.ack = a;
    @(posedge clk);
    model_edge(r, dv, a);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int code();
    return int'({bus.I1, bus.I0});
  endfunction

  vec_t vt[$];
  int sv_code;

  initial begin
    {bus.D3, bus.D2, bus.D1, bus.D0} = 4'b0000;
    bus.ack = 1'b0;
    vt = '{
      '{0, 4'b0000, 0, 0, 0, 0},
      '{1, 4'b0000, 0, 0, 0, 0},
      '{1, 4'b0100, 0, 0, 0, 0},
      '{1, 4'b0100, 0, 1, 2, 0},
      '{1, 4'b0100, 1, 0, 2, 0},
      '{1, 4'b0100, 0, 0, 2, 0},
      '{0, 4'b0000, 0, 0, 0, 0},
      '{1, 4'b0000, 0, 0, 0, 0},
      '{1, 4'b1001, 0, 0, 0, 0},
      '{1, 4'b1001, 0, 1, FIRST, 0},
      '{1, 4'b1001, 1, 0, FIRST, 0},
      '{1, 4'b1001, 0, 1, SECOND, 0},
      '{1, 4'b1001, 1, 0, SECOND, 0},
      '{1, 4'b1001, 0, 0, SECOND, 0},
      '{0, 4'b0000, 0, 0, 0, 0},
      '{1, 4'b0000, 0, 0, 0, 0},
      '{1, 4'b0100, 0, 0, 0, 0},
      '{1, 4'b0110, 0, 1, 2, 0},
      '{1, 4'b0100, 0, 1, 2, 0},
      '{1, 4'b0110, 0, 1, 2, 1},
      '{1, 4'b0100, 1, 0, 2, 1},
      '{1, 4'b0000, 0, 1, 1, 1},
      '{1, 4'b0000, 1, 0, 1, 1},
      '{1, 4'b0000, 0, 0, 1, 1},
      '{1, 4'b0000, 0, 0, 1, 1}
    };
    foreach (vt[i]) begin
      step(vt[i].rst_n, vt[i].d, vt[i].ack);
      chk($sformatf("vec%0d.valid", i), int'(bus.valid), int'(vt[i].vld));
      chk($sformatf("vec%0d.code", i), code(), vt[i].code);
      chk($sformatf("vec%0d.overrun", i), int'(bus.overrun), int'(vt[i].ovr));
    end

    // long hold on index 1 while D3 rises
    step(0, 4'b0000, 0);
    step(1, 4'b0000, 0);
    step(1, 4'b0010, 0);
    step(1, 4'b0010, 0);
    chk("hold.grant1", code(), 1);
    step(1, 4'b1010, 0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold.valid%0d", i), int'(bus.valid), 1);
      chk($sformatf("hold.code%0d", i), code(), 1);
      if (i < 9) step(1, 4'b1010, 0);
    end
    step(1, 4'b1010, 1);
    chk("hold.ackdrop", int'(bus.valid), 0);
    step(1, 4'b1010, 0);
    chk("hold.next.valid", int'(bus.valid), 1);
    chk("hold.next.code", code(), 3);

    // D2 held through reset
    step(0, 4'b0100, 0);
    step(0, 4'b0100, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 4'b0100, 0);
      chk($sformatf("held.novalid%0d", i), int'(bus.valid), 0);
    end
    step(1, 4'b0000, 0);
    step(1, 4'b0100, 0);
    chk("held.event.valid", int'(bus.valid), 0);
    step(1, 4'b0100, 0);
    chk("held.grant.valid", int'(bus.valid), 1);
    chk("held.grant.code", code(), 2);

    // reset during hold with P=1010 and overrun set
    step(0, 4'b0000, 0);
    step(1, 4'b0000, 0);
    step(1, 4'b0100, 0);
    step(1, 4'b0100, 0);
    step(1, 4'b1110, 0);
    step(1, 4'b1100, 0);
    step(1, 4'b1110, 0);
    chk("rsthold.pre.ovr", int'(bus.overrun), 1);
    chk("rsthold.pre.valid", int'(bus.valid), 1);
    step(0, 4'b1110, 0);
    chk("rsthold.valid", int'(bus.valid), 0);
    chk("rsthold.ovr", int'(bus.overrun), 0);
    chk("rsthold.code", code(), 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 4'b1110, 0);
      chk($sformatf("rsthold.nogrant%0d", i), int'(bus.valid), 0);
    end

    // randomized run against the model
    step(0, 4'b0000, 0);
    for (int i = 0; i < 600; i++) begin
      bit r;
      bit [3:0] dv;
      r = ($urandom_range(0, 59) != 0);
      dv = 4'($urandom);
      step(r, dv, bit'($urandom_range(0, 2) == 0));
      chk($sformatf("rand%0d.valid", i), int'(bus.valid), int'(m_vld));
      chk($sformatf("rand%0d.code", i), code(), m_code);
      chk($sformatf("rand%0d.overrun", i), int'(bus.overrun), int'(m_ovr));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
